// File: rtl/dac_serializer.sv
// dac_serializer: one-entry sample holding register feeding a 16-bit-frame serial DAC.
// Newest sample wins when samples outpace frames; overrun latches the loss.
module dac_serializer #(
  parameter int         CLK_DIV = 4,
  parameter logic [3:0] CTRL    = 4'b0000,
  parameter int         GAP     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dato,
  input  logic        dato_listo,
  output logic        sync,
  output logic        sclk,
  output logic        sdout,
  output logic        ocupado,
  output logic        overrun
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int GW = $clog2(GAP + 1);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;
  state_t          state_q;
  logic            listo_q, prev_q, pend_valid_q, sync_q, sclk_q, overrun_q;
  logic [11:0]     dat_q;
  logic [15:0]     pend_q, shreg_q;
  logic [5:0]      hcnt_q;
  logic [DW-1:0]   divcnt_q;
  logic [GW-1:0]   gcnt_q;
  logic            edge_d, take_d, unused_hi;
  assign edge_d    = listo_q & ~prev_q;
  assign take_d    = state_q == S_LOAD;
  assign unused_hi = ^dato[15:12];
  // hcnt_q counts sclk half-periods: 0 is a lead-in with sclk high, odd values are falls,
  // even values rises; half-period 32 closes the frame.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q      <= S_IDLE;
      listo_q      <= 1'b0;
      prev_q       <= 1'b0;
      dat_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      shreg_q      <= '0;
      hcnt_q       <= '0;
      divcnt_q     <= '0;
      gcnt_q       <= '0;
      sync_q       <= 1'b1;
      sclk_q       <= 1'b1;
      overrun_q    <= 1'b0;
    end else begin
      listo_q <= dato_listo;
      prev_q  <= listo_q;
      dat_q   <= dato[11:0];
      if (edge_d) begin
        pend_q       <= {CTRL, dat_q};
        pend_valid_q <= 1'b1;
        if (pend_valid_q && !take_d) overrun_q <= 1'b1;
      end else if (take_d) pend_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (pend_valid_q) begin
          state_q <= S_LOAD;
          sync_q  <= 1'b0;
        end
        S_LOAD: begin
          shreg_q  <= pend_q;
          hcnt_q   <= '0;
          divcnt_q <= '0;
          state_q  <= S_SHIFT;
        end
        S_SHIFT: if (divcnt_q == DW'(CLK_DIV - 1)) begin
          divcnt_q <= '0;
          hcnt_q   <= hcnt_q + 6'd1;
          if (hcnt_q == 6'd32) begin
            sclk_q  <= 1'b1;
            sync_q  <= 1'b1;
            gcnt_q  <= '0;
            state_q <= S_GAP;
          end else if (hcnt_q != 6'd0) begin
            sclk_q <= ~sclk_q;
            if (!hcnt_q[0]) shreg_q <= shreg_q << 1;
          end
        end else divcnt_q <= divcnt_q + 1'b1;
        default: if (gcnt_q == GW'(GAP - 1)) begin
          state_q <= pend_valid_q ? S_LOAD : S_IDLE;
          sync_q  <= !pend_valid_q;
        end else gcnt_q <= gcnt_q + 1'b1;
      endcase
    end
  assign sync    = sync_q;
  assign sclk    = sclk_q;
  assign sdout   = (state_q == S_LOAD || state_q == S_SHIFT) & shreg_q[15];
  assign ocupado = state_q != S_IDLE;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_dac_serializer.sv
// tb_dac_serializer: decodes DAC frames from sync/sclk/sdout and checks them against
// vectors, directed corner cases and a burst-level model of the newest-wins rule.
module tb_dac_serializer;
  localparam int CLK_DIV = 4;
  localparam int GAP     = 4;
  logic        clk = 1'b0, reset = 1'b0, dato_listo = 1'b0;
  logic [15:0] dato = '0;
  logic        sync, sclk, sdout, ocupado, overrun;
  always #5 clk = ~clk;
  dac_serializer #(.CLK_DIV(CLK_DIV), .CTRL(4'b0000), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .dato(dato), .dato_listo(dato_listo),
    .sync(sync), .sclk(sclk), .sdout(sdout), .ocupado(ocupado), .overrun(overrun)
  );
  int n_tests = 0, n_fail = 0;
  logic [15:0] fr_q[$];
  int          fall_q[$], low_q[$], gap_q[$];
  int          low_cnt = 0, hi_cnt = 0, falls = 0, sclk_edges = 0;
  logic [15:0] word = '0;
  logic        p_sclk = 1'b1, p_sync = 1'b1;
  always @(negedge clk) begin
    if (!reset) begin
      low_cnt = 0; falls = 0; word = '0; hi_cnt = 0; p_sclk = 1'b1; p_sync = 1'b1;
    end else begin
      if (sclk !== p_sclk) sclk_edges++;
      if (sync && !p_sync) begin
        fr_q.push_back(word); fall_q.push_back(falls); low_q.push_back(low_cnt);
        word = '0; falls = 0; low_cnt = 0; hi_cnt = 1;
      end else if (sync) hi_cnt++;
      if (!sync && p_sync) begin
        gap_q.push_back(hi_cnt); hi_cnt = 0; low_cnt = 1; falls = 0;
      end else if (!sync) begin
        low_cnt++;
        if (p_sclk && !sclk) begin word = {word[14:0], sdout}; falls++; end
      end
      p_sclk = sclk; p_sync = sync;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic clear_mon();
    fr_q.delete(); fall_q.delete(); low_q.delete(); gap_q.delete();
  endtask
  task automatic pulse(input logic [15:0] d, input int w);
    @(negedge clk); dato = d; dato_listo = 1'b1;
    repeat (w) @(negedge clk);
    dato_listo = 1'b0;
  endtask
  task automatic wait_n(input int n, input int budget);
    int k = 0;
    while (fr_q.size() < n && k < budget) begin @(negedge clk); k++; end
    if (fr_q.size() < n) chk("frame_timeout", fr_q.size(), n);
  endtask
  task automatic do_reset();
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); clear_mon();
  endtask
  typedef struct { logic [15:0] d; logic [15:0] exp; } vec_t;
  vec_t        tv[6];
  logic [15:0] exp_q[$];
  initial begin
    int e, k, nb;
    logic exp_ovr;
    logic [15:0] d, last;
    tv[0] = '{16'h0ABC, 16'h0ABC}; tv[1] = '{16'h0000, 16'h0000};
    tv[2] = '{16'h0FFF, 16'h0FFF}; tv[3] = '{16'hF123, 16'h0123};
    tv[4] = '{16'h0800, 16'h0800}; tv[5] = '{16'hA001, 16'h0001};
    repeat (2) @(negedge clk);
    chk("rst_sync", sync, 1); chk("rst_sclk", sclk, 1); chk("rst_sdout", sdout, 0);
    chk("rst_ocupado", ocupado, 0); chk("rst_overrun", overrun, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    // single-sample frames: word, 16 falls, sync low 33*CLK_DIV+1
    for (int i = 0; i < 6; i++) begin
      clear_mon();
      pulse(tv[i].d, 1);
      wait_n(1, 400);
      if (fr_q.size() > 0) begin
        chk($sformatf("vec%0d_word", i), fr_q[0], tv[i].exp);
        chk($sformatf("vec%0d_falls", i), fall_q[0], 16);
        chk($sformatf("vec%0d_low", i), low_q[0], 33 * CLK_DIV + 1);
      end
      chk($sformatf("vec%0d_overrun", i), overrun, 0);
      repeat (10) @(negedge clk);
    end
    // level held high captures once
    clear_mon();
    @(negedge clk); dato = 16'h0FFF; dato_listo = 1'b1;
    repeat (500) @(negedge clk);
    dato_listo = 1'b0;
    repeat (200) @(negedge clk);
    chk("held_frames", fr_q.size(), 1);
    if (fr_q.size() > 0) chk("held_word", fr_q[0], 16'h0FFF);
    // three edges around one frame: middle sample lost, overrun set
    clear_mon();
    pulse(16'h0111, 1); repeat (20) @(negedge clk);
    pulse(16'h0222, 1); repeat (10) @(negedge clk);
    pulse(16'h0333, 1);
    wait_n(2, 600);
    repeat (300) @(negedge clk);
    chk("ovr_frames", fr_q.size(), 2);
    if (fr_q.size() > 1) begin
      chk("ovr_first", fr_q[0], 16'h0111);
      chk("ovr_second", fr_q[1], 16'h0333);
    end
    chk("ovr_flag", overrun, 1);
    do_reset();
    chk("ovr_cleared", overrun, 0);
    // second edge lands on the LOAD clk of the first: both sent, GAP apart
    @(negedge clk); dato = 16'h0456; dato_listo = 1'b1;
    @(negedge clk); dato_listo = 1'b0;
    @(negedge clk); dato = 16'h0789; dato_listo = 1'b1;
    chk("lat_sync_hi", sync, 1);
    @(negedge clk); dato_listo = 1'b0;
    chk("lat_sync_lo", sync, 0);
    wait_n(2, 600);
    if (fr_q.size() > 1 && gap_q.size() > 1) begin
      chk("coin_first", fr_q[0], 16'h0456);
      chk("coin_second", fr_q[1], 16'h0789);
      chk("coin_gap", gap_q[1], GAP);
    end
    chk("coin_overrun", overrun, 0);
    // async reset mid-frame after the 7th fall
    repeat (20) @(negedge clk);
    clear_mon();
    pulse(16'h0555, 1);
    k = 0;
    while (falls < 7 && k < 300) begin @(negedge clk); k++; end
    chk("abort_reach7", falls, 7);
    reset = 1'b0;
    #1;
    chk("abort_sync", sync, 1); chk("abort_sclk", sclk, 1);
    chk("abort_sdout", sdout, 0); chk("abort_ocupado", ocupado, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    e = sclk_edges;
    repeat (300) @(negedge clk);
    chk("abort_quiet", sclk_edges, e);
    chk("abort_frames", fr_q.size(), 0);
    // ADC-rate ramp
    clear_mon();
    for (int i = 0; i < 20; i++) begin
      pulse(16'(i), 1);
      repeat (2267) @(negedge clk);
    end
    wait_n(20, 3000);
    chk("ramp_frames", fr_q.size(), 20);
    for (int i = 0; i < 20 && i < fr_q.size(); i++) chk($sformatf("ramp_%0d", i), fr_q[i], i);
    chk("ramp_overrun", overrun, 0);
    // random bursts: first edge from idle is sent, the newest later edge is sent,
    // anything between them is overwritten
    do_reset();
    exp_q.delete();
    exp_ovr = 1'b0;
    for (int b = 0; b < 15; b++) begin
      nb = $urandom_range(1, 3);
      for (int j = 0; j < nb; j++) begin
        d = 16'($urandom);
        if (j == 0) exp_q.push_back({4'h0, d[11:0]});
        last = {4'h0, d[11:0]};
        pulse(d, $urandom_range(1, 2));
        repeat ($urandom_range(1, 20)) @(negedge clk);
      end
      if (nb > 1) exp_q.push_back(last);
      if (nb == 3) exp_ovr = 1'b1;
      repeat (450) @(negedge clk);
    end
    chk("rnd_frames", fr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < fr_q.size(); i++) begin
      chk($sformatf("rnd_word%0d", i), fr_q[i], exp_q[i]);
      chk($sformatf("rnd_low%0d", i), low_q[i], 33 * CLK_DIV + 1);
    end
    chk("rnd_overrun", overrun, exp_ovr);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
